// File: rtl/cursor_pkg.sv
// cursor_pkg: shared types and constants for the hardware cursor compositor
package cursor_pkg;
  typedef logic [11:0] rgb12_t;
  localparam int CURSOR_W = 16;
  localparam int CURSOR_H = 16;
  localparam rgb12_t CURSOR_PAL1_RST = 12'hFFF;
  localparam rgb12_t CURSOR_PAL2_RST = 12'h000;
  localparam rgb12_t CURSOR_PAL3_RST = 12'hF00;
endpackage

// File: rtl/cursor_overlay_if.sv
// cursor_overlay_if: video-in/out, sprite control and palette/bitmap write bus
// master drives timing, background RGB and writes; slave (compositor) drives VGA RGB/syncs
interface cursor_overlay_if;
  logic        videoActive;
  logic [9:0]  hPos;
  logic [9:0]  vPos;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  red_in;
  logic [3:0]  green_in;
  logic [3:0]  blue_in;
  logic [9:0]  cursor_x;
  logic [9:0]  cursor_y;
  logic        cursor_en;
  logic        pal_wr;
  logic [1:0]  pal_idx;
  logic [11:0] pal_data;
  logic        bmp_wr;
  logic [3:0]  bmp_addr;
  logic [31:0] bmp_data;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  modport master (
    output videoActive, hPos, vPos, hsync_in, vsync_in, red_in, green_in, blue_in,
    output cursor_x, cursor_y, cursor_en, pal_wr, pal_idx, pal_data, bmp_wr, bmp_addr, bmp_data,
    input  red, green, blue, hsync, vsync
  );
  modport slave (
    input  videoActive, hPos, vPos, hsync_in, vsync_in, red_in, green_in, blue_in,
    input  cursor_x, cursor_y, cursor_en, pal_wr, pal_idx, pal_data, bmp_wr, bmp_addr, bmp_data,
    output red, green, blue, hsync, vsync
  );
endinterface

// File: rtl/cursor_bitmap_regs.sv
// cursor_bitmap_regs: 16x32 resettable sprite bitmap, registered write, async row read
// ports: clk40, reset_n (async low), i_wr/i_waddr/i_wdata write port, i_raddr -> o_rdata read port
module cursor_bitmap_regs
  import cursor_pkg::*;
(
  input  logic                  clk40,
  input  logic                  reset_n,
  input  logic                  i_wr,
  input  logic [3:0]            i_waddr,
  input  logic [2*CURSOR_W-1:0] i_wdata,
  input  logic [3:0]            i_raddr,
  output logic [2*CURSOR_W-1:0] o_rdata
);
  logic [2*CURSOR_W-1:0] r_rows [CURSOR_H];
  always_ff @(posedge clk40 or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < CURSOR_H; i++) r_rows[i] <= '0;
    else if (i_wr)
      r_rows[i_waddr] <= i_wdata;
  assign o_rdata = r_rows[i_raddr];
endmodule

// File: rtl/cursor_overlay.sv
// cursor_overlay: composites a 16x16 2bpp sprite over background RGB with 1-cycle latency
// ports: clk40, reset_n (async low), bus (cursor_overlay_if.slave: timing/RGB in, writes, RGB/syncs out)
// optional macro CURSOR_BLINK_EN: 6-bit frame counter hides the sprite while bit 5 is set
module cursor_overlay
  import cursor_pkg::*;
#(
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic clk40,
  input  logic reset_n,
  cursor_overlay_if.slave bus
);
  logic                  r_vs_prev;
  logic [9:0]            r_x_s;
  logic [9:0]            r_y_s;
  logic                  r_en_s;
  rgb12_t                r_pal [4];
  rgb12_t                r_rgb;
  logic                  r_hs;
  logic                  r_vs;
  logic                  w_boundary;
  logic                  w_vis;
  logic                  w_hit;
  logic [10:0]           w_dx;
  logic [10:0]           w_dy;
  logic [2*CURSOR_W-1:0] w_row;
  logic [1:0]            w_idx;
  rgb12_t                w_pix;
  assign w_boundary = (bus.vsync_in == VSYNC_POL) && (r_vs_prev != bus.vsync_in);
  // 11-bit differences: a position left of/above the sprite goes negative (bit 10 set) instead of wrapping
  assign w_dx  = {1'b0, bus.hPos} - {1'b0, r_x_s};
  assign w_dy  = {1'b0, bus.vPos} - {1'b0, r_y_s};
  assign w_hit = bus.videoActive && w_vis && (w_dx[10:4] == 7'd0) && (w_dy[10:4] == 7'd0);
  assign w_idx = w_row[{w_dx[3:0], 1'b0} +: 2];
  assign w_pix = !bus.videoActive ? '0 :
                 (w_hit && w_idx != 2'd0) ? r_pal[w_idx] :
                 {bus.red_in, bus.green_in, bus.blue_in};
  cursor_bitmap_regs u_bitmap (
    .clk40   (clk40),
    .reset_n (reset_n),
    .i_wr    (bus.bmp_wr),
    .i_waddr (bus.bmp_addr),
    .i_wdata (bus.bmp_data),
    .i_raddr (w_dy[3:0]),
    .o_rdata (w_row)
  );
`ifdef CURSOR_BLINK_EN
  logic [5:0] r_frame_cnt;
  always_ff @(posedge clk40 or negedge reset_n)
    if (!reset_n) r_frame_cnt <= '0;
    else if (w_boundary) r_frame_cnt <= r_frame_cnt + 6'd1;
  assign w_vis = r_en_s & ~r_frame_cnt[5];
`else
  assign w_vis = r_en_s;
`endif
  always_ff @(posedge clk40 or negedge reset_n)
    if (!reset_n) begin
      r_vs_prev <= 1'b0;
      r_x_s     <= '0;
      r_y_s     <= '0;
      r_en_s    <= 1'b0;
    end else begin
      r_vs_prev <= bus.vsync_in;
      if (w_boundary) begin
        r_x_s  <= bus.cursor_x;
        r_y_s  <= bus.cursor_y;
        r_en_s <= bus.cursor_en;
      end
    end
  // entry 0 is transparent and never written; it only exists to keep the read index simple
  always_ff @(posedge clk40 or negedge reset_n)
    if (!reset_n) begin
      r_pal[0] <= '0;
      r_pal[1] <= CURSOR_PAL1_RST;
      r_pal[2] <= CURSOR_PAL2_RST;
      r_pal[3] <= CURSOR_PAL3_RST;
    end else if (bus.pal_wr && bus.pal_idx != 2'd0)
      r_pal[bus.pal_idx] <= bus.pal_data;
  always_ff @(posedge clk40 or negedge reset_n)
    if (!reset_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_rgb <= w_pix;
      r_hs  <= bus.hsync_in;
      r_vs  <= bus.vsync_in;
    end
  assign {bus.red, bus.green, bus.blue} = r_rgb;
  assign bus.hsync = r_hs;
  assign bus.vsync = r_vs;
endmodule

// File: tb/tb_cursor_overlay.sv
// tb_cursor_overlay: table-driven directed check of the cursor compositor plus reset/write corner sequences
module tb_cursor_overlay;
  typedef enum logic [1:0] {PIX, BND, BMP, CUR} op_t;
  typedef struct {
    op_t         op;
    logic        va;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic [11:0] bg;
    logic [11:0] ex;
    logic [31:0] d;
  } vec_t;
  logic clk40 = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vq[$];
  cursor_overlay_if bus();
  cursor_overlay #(.VSYNC_POL(1'b1)) dut (
    .clk40   (clk40),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk40 = ~clk40;
  function automatic vec_t px(logic va, logic [9:0] h, logic [9:0] v, logic hs, logic [11:0] bg, logic [11:0] ex);
    return '{PIX, va, h, v, hs, bg, ex, 32'd0};
  endfunction
  function automatic vec_t bnd();
    return '{BND, 1'b0, 10'd0, 10'd0, 1'b0, 12'd0, 12'd0, 32'd0};
  endfunction
  function automatic vec_t bmp(logic [9:0] row, logic [31:0] d);
    return '{BMP, 1'b0, row, 10'd0, 1'b0, 12'd0, 12'd0, d};
  endfunction
  function automatic vec_t cur(logic [9:0] x, logic [9:0] y, logic en);
    return '{CUR, en, x, y, 1'b0, 12'd0, 12'd0, 32'd0};
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk40);
    #1;
  endtask
  task automatic drive(logic va, logic [9:0] h, logic [9:0] v, logic hs, logic vs, logic [11:0] bg);
    bus.videoActive = va;
    bus.hPos = h;
    bus.vPos = v;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    {bus.red_in, bus.green_in, bus.blue_in} = bg;
  endtask
  task automatic pixel(int idx, logic va, logic [9:0] h, logic [9:0] v, logic hs, logic [11:0] bg, logic [11:0] ex);
    drive(va, h, v, hs, 1'b0, bg);
    tick();
    chk("rgb", idx, {20'd0, bus.red, bus.green, bus.blue}, {20'd0, ex});
    chk("hsync", idx, {31'd0, bus.hsync}, {31'd0, hs});
    chk("vsync", idx, {31'd0, bus.vsync}, 32'd0);
  endtask
  task automatic boundary(int idx);
    drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 12'h5A5);
    tick();
    chk("vsync_lead", idx, {31'd0, bus.vsync}, 32'd1);
    chk("blank_rgb", idx, {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
    drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 12'h5A5);
    tick();
  endtask
  task automatic bmp_write(logic [3:0] row, logic [31:0] d);
    bus.bmp_wr = 1'b1;
    bus.bmp_addr = row;
    bus.bmp_data = d;
    tick();
    bus.bmp_wr = 1'b0;
  endtask
  initial begin
    vq.push_back(px(1'b1, 10'd100, 10'd50, 1'b0, 12'h123, 12'h123));
    vq.push_back(px(1'b0, 10'd100, 10'd50, 1'b1, 12'h777, 12'h000));
    vq.push_back(bnd());
    vq.push_back(px(1'b1, 10'd100, 10'd50, 1'b0, 12'h456, 12'h456));
    vq.push_back(px(1'b1, 10'd5,   10'd5,  1'b1, 12'hABC, 12'hABC));
    vq.push_back(bmp(10'd0, 32'h0000_0001));
    vq.push_back(px(1'b1, 10'd100, 10'd50, 1'b0, 12'h456, 12'hFFF));
    vq.push_back(px(1'b1, 10'd101, 10'd50, 1'b0, 12'h456, 12'h456));
    vq.push_back(px(1'b1, 10'd99,  10'd50, 1'b0, 12'h456, 12'h456));
    vq.push_back(px(1'b1, 10'd100, 10'd51, 1'b0, 12'h456, 12'h456));
    vq.push_back(px(1'b0, 10'd100, 10'd50, 1'b0, 12'h456, 12'h000));
    vq.push_back(cur(10'd200, 10'd50, 1'b1));
    vq.push_back(px(1'b1, 10'd100, 10'd50, 1'b0, 12'h321, 12'hFFF));
    vq.push_back(px(1'b1, 10'd200, 10'd50, 1'b0, 12'h321, 12'h321));
    vq.push_back(bmp(10'd15, 32'hC000_0000));
    vq.push_back(bnd());
    vq.push_back(px(1'b1, 10'd200, 10'd50, 1'b0, 12'h321, 12'hFFF));
    vq.push_back(px(1'b1, 10'd100, 10'd50, 1'b0, 12'h321, 12'h321));
    vq.push_back(px(1'b1, 10'd215, 10'd65, 1'b0, 12'h321, 12'hF00));
    vq.push_back(px(1'b1, 10'd216, 10'd65, 1'b0, 12'h321, 12'h321));
    vq.push_back(px(1'b1, 10'd215, 10'd66, 1'b0, 12'h321, 12'h321));
    vq.push_back(bmp(10'd0, 32'hFFFF_FFFF));
    vq.push_back(cur(10'd1016, 10'd50, 1'b1));
    vq.push_back(bnd());
    vq.push_back(px(1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'hF00));
    vq.push_back(px(1'b1, 10'd1023, 10'd50, 1'b1, 12'h0AA, 12'hF00));
    vq.push_back(px(1'b1, 10'd0,    10'd50, 1'b0, 12'h0AA, 12'h0AA));
    vq.push_back(px(1'b1, 10'd1015, 10'd50, 1'b0, 12'h0AA, 12'h0AA));
    vq.push_back(px(1'b1, 10'd1016, 10'd49, 1'b0, 12'h0AA, 12'h0AA));
    vq.push_back(px(1'b1, 10'd1023, 10'd65, 1'b0, 12'h0AA, 12'h0AA));
    vq.push_back(px(1'b0, 10'd1020, 10'd50, 1'b0, 12'h0AA, 12'h000));
    vq.push_back(cur(10'd1016, 10'd50, 1'b0));
    vq.push_back(bnd());
    vq.push_back(px(1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'h0AA));
    vq.push_back(cur(10'd1016, 10'd50, 1'b1));
    vq.push_back(bnd());
    vq.push_back(px(1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'hF00));
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 12'hFFF);
    bus.cursor_x = 10'd100;
    bus.cursor_y = 10'd50;
    bus.cursor_en = 1'b1;
    bus.pal_wr = 1'b0;
    bus.pal_idx = 2'd0;
    bus.pal_data = 12'd0;
    bus.bmp_wr = 1'b0;
    bus.bmp_addr = 4'd0;
    bus.bmp_data = 32'd0;
    tick();
    tick();
    chk("rst_rgb", 0, {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
    chk("rst_hsync", 0, {31'd0, bus.hsync}, 32'd0);
    reset_n = 1'b1;
    foreach (vq[i]) begin
      case (vq[i].op)
        PIX: pixel(i, vq[i].va, vq[i].h, vq[i].v, vq[i].hs, vq[i].bg, vq[i].ex);
        BND: boundary(i);
        BMP: bmp_write(vq[i].h[3:0], vq[i].d);
        CUR: begin
          bus.cursor_x = vq[i].h;
          bus.cursor_y = vq[i].v;
          bus.cursor_en = vq[i].va;
        end
      endcase
    end
    drive(1'b1, 10'd1016, 10'd50, 1'b0, 1'b0, 12'h0AA);
    bus.pal_wr = 1'b1;
    bus.pal_idx = 2'd1;
    bus.pal_data = 12'h0F0;
    bus.bmp_wr = 1'b1;
    bus.bmp_addr = 4'd0;
    bus.bmp_data = 32'h0000_0001;
    tick();
    bus.pal_wr = 1'b0;
    bus.bmp_wr = 1'b0;
    chk("wr_cycle_old", 100, {20'd0, bus.red, bus.green, bus.blue}, 32'h0000_0F00);
    pixel(101, 1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'h0F0);
    pixel(102, 1'b1, 10'd1017, 10'd50, 1'b0, 12'h0AA, 12'h0AA);
    pixel(103, 1'b1, 10'd1016, 10'd50, 1'b1, 12'h0AA, 12'h0F0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", 104, {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
    chk("async_rst_hsync", 104, {31'd0, bus.hsync}, 32'd0);
    tick();
    chk("held_rst_rgb", 105, {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
    reset_n = 1'b1;
    pixel(106, 1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'h0AA);
    boundary(107);
    pixel(108, 1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'h0AA);
    bmp_write(4'd0, 32'h0000_0001);
    pixel(109, 1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, 12'hFFF);
`ifdef CURSOR_BLINK_EN
    for (int f = 2; f <= 65; f++) begin
      boundary(200 + f);
      pixel(200 + f, 1'b1, 10'd1016, 10'd50, 1'b0, 12'h0AA, ((f % 64) < 32) ? 12'hFFF : 12'h0AA);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cursor_overlay.md
# cursor_overlay

Hardware cursor compositor downstream of the `background` layer. Consumes background RGB plus `frameGenerator` timing (`videoActive`, `hPos`, `vPos`, syncs) and overlays a 16x16, 2-bit-per-pixel sprite at a software-set position. Emits the final 4:4:4 RGB and re-aligned syncs to the VGA pins with one `clk40` cycle of latency.

## Interface
- `VSYNC_POL`, 1'b1: active level of `vsync_in`; the frame boundary is its leading edge.
- `clk40`  in  1  pixel clock; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `videoActive`  in  1  visible-pixel flag, aligned with `red_in`/`hPos`.
- `hPos`, `vPos`  in  10 each  current pixel coordinates.
- `hsync_in`, `vsync_in`  in  1 each  syncs aligned with `red_in`.
- `red_in`, `green_in`, `blue_in`  in  4 each  background pixel.
- `cursor_x`, `cursor_y`  in  10 each  sprite top-left; sampled once per frame.
- `cursor_en`  in  1  sprite enable; sampled once per frame.
- `pal_wr`  in  1  palette write strobe.
- `pal_idx`  in  2  palette entry; index 0 is ignored (transparent).
- `pal_data`  in  12  {R,G,B} 4:4:4.
- `bmp_wr`  in  1  bitmap row write strobe.
- `bmp_addr`  in  4  bitmap row.
- `bmp_data`  in  32  16 pixels; pixel c = bits [2c+1:2c].
- `red`, `green`, `blue`  out  4 each  composited pixel, registered.
- `hsync`, `vsync`  out  1 each  syncs delayed to match RGB.

## Operation
- Frame boundary: the cycle where `vsync_in == VSYNC_POL` and the registered previous `vsync_in` differs. On it, latch `cursor_x`, `cursor_y`, `cursor_en` into shadow registers. Mid-frame changes are invisible until the next boundary.
- Hit test uses shadow values and 11-bit arithmetic (no wrap):
  - `dx = hPos - x_s`, `dy = vPos - y_s`.
  - Hit when both are in [0,15], `videoActive` = 1, and sprite is enabled.
  - A sprite at x=1020 clips at column 1023; it never wraps to column 0.
- Pixel index = `bitmap[dy][2*dx+1 : 2*dx]`.
  - Index 0, or no hit: output background.
  - Index 1-3: output `palette[index]`.
- `videoActive` = 0: RGB output is 0, regardless of background input.
- Palette writes and bitmap writes take effect on the cycle after the strobe.
  - A read of the same row or entry in the write cycle returns the old value.
  - Simultaneous `pal_wr` and `bmp_wr` are independent; both commit.
- Reset values:
  - RGB, `hsync`, `vsync` outputs: 0.
  - Bitmap: all zeros (fully transparent).
  - Palette: entry 1 = 12'hFFF, entry 2 = 12'h000, entry 3 = 12'hF00.
  - Shadow registers: x = 0, y = 0, en = 0.
  - Frame counter: 0.
- Reset mid-line: outputs go to 0 at once. Compositing resumes on the first cycle after release, but the sprite stays disabled until the next frame boundary.

## Timing
- Latency: exactly 1 `clk40` cycle from `red_in`/`hsync_in`/`vsync_in` to `red`/`hsync`/`vsync`, for every pixel, sync and blank.
- Hit test and bitmap read are combinational from registered storage, followed by one output register. No multi-cycle paths.
- Shadow latch is visible from the boundary cycle + 1.
- No backpressure; writes are fire-and-forget with no acknowledge.

## Configuration
- `CURSOR_BLINK_EN` defined:
  - A 6-bit frame counter increments at each frame boundary and wraps 63 -> 0.
  - The sprite is suppressed while counter[5] = 1, giving 32 frames on and 32 frames off.
- Not defined:
  - No counter is built; the sprite is visible whenever `en_s` = 1.

## Structure
- `cursor_pkg` holds:
  - typedef `rgb12_t`;
  - constants `CURSOR_W` = 16, `CURSOR_H` = 16;
  - palette reset constants `CURSOR_PAL1/2/3_RST`.
- Sub-module `cursor_bitmap_regs`: 16x32 flop array with a registered write port and an async read by row. It is flops, not BRAM, because it needs a reset.
- The top holds: shadow registers, edge detect, hit test, palette, mux, output register and the optional blink counter.

## Test plan
- Reset release, no writes, `cursor_en` = 1: the output equals the background delayed 1 cycle for a full frame. At frame 2, the bitmap is still transparent, so the output still equals the background.
- Write row 0 = 32'h0000_0001, set x = 100, y = 50, then frame boundary: pixel (100,50) = 12'hFFF and (101,50) = background.
- Change `cursor_x` to 200 mid-frame: the sprite stays at x = 100 until the next leading edge of `vsync_in`, then moves.
- Sprite at x = 1016, fill row 0 with index 3: pixels 1016-1023 are 12'hF00 and pixel 0 is background (no wrap). `videoActive` low yields RGB 0.
- Issue `pal_wr` idx 1 = 12'h0F0 and `bmp_wr` in the same cycle while the sprite is displayed: both commit, and the next cycle shows the new colour and row.
- With `CURSOR_BLINK_EN` defined: the sprite is visible in frames 0-31, hidden in frames 32-63, and visible again at frame 64. `reset_n` asserted mid-frame forces all outputs to 0 asynchronously.
